// File: rtl/bf16_accum_ctrl.sv
// bf16_accum_ctrl: streams LEN bfloat16 elements through one combinational adder and returns
// their sum. The first element is loaded directly, because the adder does not handle zero
// operands. The following elements are added to the accumulator at one element per cycle.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   start, len           begin a reduction of len elements (sampled in IDLE only)
//   busy                 controller is not in IDLE
//   in_valid/in_data     element stream; in_ready qualifies the transfer
//   out_valid/out_data   result handshake; out_ready pops the result
//   ovf                  sticky flag: the accumulator reached exponent 8'hFF
//
// Optional feature: define BF16_ACC_OVF_EN to build the ovf detector.
// When it is undefined, ovf is tied to 0.

// Truncating bf16 adder with no special cases for zero, NaN, Inf or subnormal operands.
// A result exponent that reaches 8'hFF saturates to infinity.
module bfloat16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  logic        a_big;
  logic [15:0] hi, lo;
  logic [7:0]  diff;
  logic [10:0] mh_x, ml_full, ml_x, d, norm;
  logic [11:0] s12;
  logic [8:0]  exp_w;
  logic [6:0]  mant;
  logic [3:0]  lz;
  logic        zero;

  always_comb begin
    a_big   = a[14:0] >= b[14:0];
    hi      = a_big ? a : b;
    lo      = a_big ? b : a;
    diff    = hi[14:7] - lo[14:7];
    // Three guard bits keep the subtraction exact enough to renormalise.
    mh_x    = {1'b1, hi[6:0], 3'b000};
    ml_full = {1'b1, lo[6:0], 3'b000};
    ml_x    = (diff > 8'd10) ? 11'd0 : (ml_full >> diff);
    s12     = 12'd0;
    d       = 11'd0;
    norm    = 11'd0;
    lz      = 4'd0;
    zero    = 1'b0;
    exp_w   = {1'b0, hi[14:7]};
    mant    = 7'd0;
    if (hi[15] == lo[15]) begin
      s12 = {1'b0, mh_x} + {1'b0, ml_x};
      if (s12[11]) begin
        exp_w = {1'b0, hi[14:7]} + 9'd1;
        mant  = 7'(s12 >> 4);
      end else begin
        mant  = 7'(s12 >> 3);
      end
    end else begin
      d = mh_x - ml_x;
      for (int i = 0; i < 11; i++) begin
        if (d[i]) lz = 4'(10 - i);
      end
      norm = d << lz;
      mant = 7'(norm >> 3);
      if (d == 11'd0 || {5'd0, lz} > {1'b0, hi[14:7]}) zero = 1'b1;
      else exp_w = {1'b0, hi[14:7]} - {5'd0, lz};
    end
    if (zero)                 sum = 16'h0000;
    else if (exp_w >= 9'd255) sum = {hi[15], 8'hFF, 7'h00};
    else                      sum = {hi[15], exp_w[7:0], mant};
  end
endmodule

module bf16_accum_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  input  logic             out_ready,
  output logic             ovf
);
  typedef enum logic [1:0] {StIdle, StFirst, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d, rem_dec;
  logic [15:0]      add_sum;

  bfloat16_add u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

  // The counter saturates at zero and never wraps.
  assign rem_dec = (rem_q != '0) ? rem_q - 1'b1 : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= 16'h0000;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d = len;
          if (len == '0) begin
            acc_d   = 16'h0000;
            state_d = StDone;
          end else begin
            state_d = StFirst;
          end
        end
      end
      StFirst: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          rem_d   = rem_dec;
          state_d = (rem_q == LEN_W'(1)) ? StDone : StAccum;
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          rem_d = rem_dec;
          if (rem_q == LEN_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign out_data = acc_q;

`ifdef BF16_ACC_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      ovf_q <= 1'b0;
    end else if (in_valid && in_ready && acc_d[14:7] == 8'hFF) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_bf16_accum_ctrl.sv
module tb_bf16_accum_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        ovf;

  int checks = 0;
  int errors = 0;

`ifdef BF16_ACC_OVF_EN
  localparam logic OvfExp = 1'b1;
`else
  localparam logic OvfExp = 1'b0;
`endif

  bf16_accum_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_red(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
  endtask

  task automatic push(input string tag, input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    chk({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [15:0] exp);
    chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_out_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 16'h0; out_ready = 1'b0;
    #12;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    step();
    reset = 1'b0;
    step();

    // 1 + 2 = 3, continuous stream.
    begin_red(8'd2);
    chk("t1_busy", {15'd0, busy}, 16'd1);
    push("t1_e0", 16'h3F80);
    push("t1_e1", 16'h4000);
    pop("t1", 16'h4040);

    // Four ones with stalls; a stray start mid-run must be ignored.
    begin_red(8'd4);
    push("t2_e0", 16'h3F80);
    start = 1'b1; len = 8'd0;
    step();
    chk("t2_stall_out_valid", {15'd0, out_valid}, 16'd0);
    step();
    start = 1'b0;
    chk("t2_stall_in_ready", {15'd0, in_ready}, 16'd1);
    push("t2_e1", 16'h3F80);
    push("t2_e2", 16'h3F80);
    push("t2_e3", 16'h3F80);
    pop("t2", 16'h4080);

    // 3 + (-1) = 2: subtraction path.
    begin_red(8'd2);
    push("t3_e0", 16'h4040);
    push("t3_e1", 16'hBF80);
    pop("t3", 16'h4000);

    // len = 0: straight to DONE with zero; result held while out_ready is low.
    begin_red(8'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_out_valid", {15'd0, out_valid}, 16'd1);
      chk("t4_out_data", out_data, 16'h0000);
      chk("t4_in_ready", {15'd0, in_ready}, 16'd0);
      step();
    end
    pop("t4", 16'h0000);

    // Exponent saturation: 2^127 + 2^127 -> +Inf.
    begin_red(8'd2);
    push("t5_e0", 16'h7F00);
    push("t5_e1", 16'h7F00);
    chk("t5_ovf", {15'd0, ovf}, {15'd0, OvfExp});
    pop("t5", 16'h7F80);
    chk("t5_ovf_hold", {15'd0, ovf}, {15'd0, OvfExp});
    begin_red(8'd1);
    chk("t5_ovf_clear", {15'd0, ovf}, 16'd0);
    push("t5_e2", 16'h4000);
    pop("t5b", 16'h4000);

    // Asynchronous reset mid-ACCUM after 3 of 8 elements.
    begin_red(8'd8);
    push("t6_e0", 16'h3F80);
    push("t6_e1", 16'h3F80);
    push("t6_e2", 16'h3F80);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_busy", {15'd0, busy}, 16'd0);
    chk("t6_rst_in_ready", {15'd0, in_ready}, 16'd0);
    chk("t6_rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("t6_rst_out_data", out_data, 16'h0000);
    step();
    reset = 1'b0;
    step();
    begin_red(8'd1);
    push("t6_e3", 16'h3F80);
    pop("t6", 16'h3F80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bf16_accum_ctrl.md
BF16_ACCUM_CTRL -- requirements
Module: bf16_accum_ctrl

Interface
REQ-001 Parameter: LEN_W, default 8, width of the vector-length field and element counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new reduction; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of bf16 elements to sum; latched when start is accepted.
REQ-006 busy  output  1  high in any state other than IDLE.
REQ-007 in_valid  input  1  element stream valid.
REQ-008 in_data  input  16  bf16 element {sign, exp[7:0], mant[6:0]}.
REQ-009 in_ready  output  1  controller accepts in_data this cycle.
REQ-010 out_valid  output  1  reduction result available.
REQ-011 out_data  output  16  bf16 sum.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 ovf  output  1  sticky exponent-saturation flag (see Configuration).

Function
REQ-014 The block shall instantiate exactly one combinational bfloat16_add, with operand a = accumulator register and operand b = in_data.
REQ-015 FSM states: IDLE, FIRST, ACCUM, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; on start=1, latch len into remaining counter and go to FIRST, or to DONE with acc=16'h0000 if len==0.
REQ-017 FIRST: in_ready=1; on in_valid, load acc <= in_data directly (no addition, since the adder mishandles zero operands), decrement remaining, go to DONE if remaining was 1, else ACCUM.
REQ-018 ACCUM: in_ready=1; on in_valid, acc <= adder result, decrement remaining; after the element that brings remaining to 0, go to DONE.
REQ-019 A transfer occurs only on in_valid && in_ready; in_valid low stalls the FSM with no state change.
REQ-020 Throughput: one element per cycle; out_valid rises the cycle after the last element is accepted.
REQ-021 DONE: out_valid=1, out_data=acc, in_ready=0; out_data stable while out_ready=0; on out_ready=1, go to IDLE.
REQ-022 start asserted outside IDLE shall be ignored; len changes outside IDLE shall have no effect.
REQ-023 out_data shall equal acc in every state; only DONE qualifies it via out_valid.
REQ-024 Remaining counter is LEN_W bits, loaded from len and never wraps (decrement only on accepted elements while nonzero).

Reset
REQ-025 reset=1 shall force IDLE immediately, independent of clk, including mid-reduction.
REQ-026 Reset values: acc=16'h0000, remaining=0, ovf=0, busy=0, in_ready=0, out_valid=0, out_data=16'h0000.
REQ-027 A reduction interrupted by reset shall leave no residue; the next start begins cleanly.

Configuration
REQ-028 Macro BF16_ACC_OVF_EN: when defined, ovf is cleared on accepted start and set (sticky until next start or reset) when any value written to acc has exp field 8'hFF.
REQ-029 Without BF16_ACC_OVF_EN, ovf shall be tied to 0 and no detection logic built; all other behaviour identical.

Verification
REQ-030 len=2, elements 16'h3F80, 16'h4000, in_valid continuous -> out_valid one cycle after 2nd accept, out_data=16'h4040.
REQ-031 len=4, four 16'h3F80 with in_valid low on cycles 2 and 3 -> stalls honoured, out_data=16'h4080.
REQ-032 len=2, 16'h4040 then 16'hBF80 -> out_data=16'h4000 (subtraction path, sign positive).
REQ-033 len=0 with start -> DONE next cycle, out_data=16'h0000, no in_ready pulse; out_ready held low 5 cycles -> out_valid and out_data stable.
REQ-034 BF16_ACC_OVF_EN defined, len=2, 16'h7F00 twice -> out_data=16'h7F80, ovf=1; next start clears ovf.
REQ-035 reset pulsed mid-ACCUM after 3 of 8 elements -> outputs at reset values asynchronously; new start len=1, 16'h3F80 -> out_data=16'h3F80.
